addsub_result_checker: RTL and testbench

- Self-checking consumer of the 4-bit adder/subtractor result interface; sits on the far side of the DUT from the stimulus driver.
- Samples each operand/mode/result/carry tuple and recomputes the golden {c,r}.
- Flags mismatches, counts passes and fails, and captures the first failing tuple for debug.
- Synthesizable so the same block serves on-chip BIST and simulation benches.

---
 rtl/addsub_result_checker.sv | 119 +++++++++++
 tb/tb_addsub_result_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_result_checker.sv
// Self-checking consumer for the W-bit adder/subtractor result interface.
// Recomputes the golden {c,r}, emits a verdict 2 cycles after each tuple, and keeps pass/fail statistics.
module addsub_result_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             m,
  input  logic [W-1:0]     r,
  input  logic             c,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [3*W+1:0]   ff_info,
  output logic [1:0]       state
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PASSING = 2'b01,
    FAILED  = 2'b10
  } state_e;

  typedef struct packed {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] r;
    logic [W:0]   gold;
  } tuple_t;

  logic [STAGES:1]  vld_pipe_q;
  tuple_t           s1_q, s1_d;
  logic             pass_q;
  logic             s1_pass;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q;
  logic [3*W+1:0]   ff_q;
  state_e           state_q;

  // Subtract is a + ~b + 1, so carry-out doubles as the "no borrow" flag.
  always_comb begin
    s1_d      = '0;
    s1_d.m    = m;
    s1_d.a    = a;
    s1_d.b    = b;
    s1_d.c    = c;
    s1_d.r    = r;
    s1_d.gold = {1'b0, a} + {1'b0, (m ? ~b : b)} + {{W{1'b0}}, m};
  end

  assign s1_pass = ({s1_q.c, s1_q.r} == s1_q.gold);

  always_comb begin
    pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
    fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      pass_q     <= 1'b0;
    end else if (clear) begin
      vld_pipe_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid)      s1_q   <= s1_d;
      if (vld_pipe_q[1]) pass_q <= s1_pass;
    end
  end

  // Statistics and FSM update on the same edge the verdict is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ff_q       <= '0;
      state_q    <= IDLE;
    end else if (clear) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ff_q       <= '0;
      state_q    <= IDLE;
    end else if (vld_pipe_q[1]) begin
      if (s1_pass) begin
        pass_cnt_q <= pass_cnt_d;
        if (state_q == IDLE) state_q <= PASSING;
      end else begin
        fail_cnt_q <= fail_cnt_d;
        err_q      <= 1'b1;
        state_q    <= FAILED;
        if (!err_q) ff_q <= {s1_q.m, s1_q.a, s1_q.b, s1_q.c, s1_q.r};
      end
    end
  end

  assign chk_valid  = vld_pipe_q[STAGES];
  assign chk_pass   = pass_q;
  assign err_sticky = err_q;
  assign pass_count = pass_cnt_q;
  assign fail_count = fail_cnt_q;
  assign ff_info    = ff_q;
  assign state      = state_q;

endmodule

// File: tb/tb_addsub_result_checker.sv
// Scoreboard bench: driver pushes expected verdicts, negedge monitor pops and compares against an arithmetic model.
module tb_addsub_result_checker;
  logic       clk = 1'b0, rst_n = 1'b1, clear = 1'b0, in_valid = 1'b0, m = 1'b0, c = 1'b0;
  logic [3:0] a = '0, b = '0, r = '0;

  logic        chk_valid, chk_pass, err_sticky;
  logic [7:0]  pass_count, fail_count;
  logic [13:0] ff_info;
  logic [1:0]  state;
  logic        chk_valid3, chk_pass3, err_sticky3;
  logic [2:0]  pass_count3, fail_count3;
  logic [13:0] ff_info3;
  logic [1:0]  state3;

  addsub_result_checker #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .m(m), .r(r), .c(c),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .err_sticky(err_sticky), .pass_count(pass_count),
    .fail_count(fail_count), .ff_info(ff_info), .state(state));

  addsub_result_checker #(.W(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .m(m), .r(r), .c(c),
    .chk_valid(chk_valid3), .chk_pass(chk_pass3), .err_sticky(err_sticky3), .pass_count(pass_count3),
    .fail_count(fail_count3), .ff_info(ff_info3), .state(state3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          pass;
    int          due;
    logic [13:0] info;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;
  int m_pc, m_fc, m_pc3;
  bit m_sticky, m_anypass, pend_clear;
  logic [13:0] m_ff;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    m_pc = 0; m_fc = 0; m_pc3 = 0; m_sticky = 0; m_anypass = 0; m_ff = '0;
  endtask

  // Reference result as a 5-bit integer {carry, result}.
  function automatic int golden(int ta, int tb, bit tm);
    if (!tm) return ta + tb;
    return ((ta >= tb) ? 16 : 0) + ((ta - tb + 16) % 16);
  endfunction

  task automatic drive(bit iv, int ta, int tb, bit tm, int tr, bit tc);
    exp_t e;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = iv; a = 4'(ta); b = 4'(tb); m = tm; r = 4'(tr); c = tc;
    if (iv) begin
      e.pass = (golden(ta, tb, tm) == (tc ? 16 : 0) + tr);
      e.due  = cyc + 2;
      e.info = {tm, 4'(ta), 4'(tb), tc, 4'(tr)};
      q.push_back(e);
    end
  endtask

  task automatic drive_good(int ta, int tb, bit tm);
    int g;
    g = golden(ta, tb, tm);
    drive(1'b1, ta, tb, tm, g % 16, g >= 16);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_clear(bit with_valid);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = with_valid;
    a = 4'($urandom); b = 4'($urandom); m = 1'($urandom); r = 4'($urandom); c = 1'($urandom);
    pend_clear = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    #1;
    chk("rst_chk_valid", 64'(chk_valid), 0);
    chk("rst_pass_count", 64'(pass_count), 0);
    chk("rst_fail_count", 64'(fail_count), 0);
    chk("rst_err_sticky", 64'(err_sticky), 0);
    chk("rst_ff_info", 64'(ff_info), 0);
    chk("rst_state", 64'(state), 0);
    q.delete(); reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_valid) begin
      if (q.size() == 0) chk("spurious_verdict", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("verdict", 64'(chk_pass), 64'(e.pass));
        if (e.pass) begin
          if (m_pc < 255) m_pc++;
          if (m_pc3 < 7) m_pc3++;
          m_anypass = 1;
        end else begin
          if (m_fc < 255) m_fc++;
          if (!m_sticky) m_ff = e.info;
          m_sticky = 1;
        end
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      chk("missing_verdict", 0, 1);
      void'(q.pop_front());
    end
    chk("pass_count", 64'(pass_count), 64'(m_pc));
    chk("fail_count", 64'(fail_count), 64'(m_fc));
    chk("pass_count_sat3", 64'(pass_count3), 64'(m_pc3));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("ff_info", 64'(ff_info), 64'(m_ff));
    chk("state", 64'(state), m_sticky ? 64'd2 : (m_anypass ? 64'd1 : 64'd0));
    if (pend_clear) begin
      q.delete(); reset_model(); pend_clear = 1'b0;
    end
  end

  initial begin
    reset_model();
    pend_clear = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("init_state", 64'(state), 0);
    chk("init_chk_valid", 64'(chk_valid), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed all-pass sequence.
    drive(1'b1, 5, 3, 1'b0, 8, 1'b0);
    drive(1'b1, 5, 3, 1'b1, 2, 1'b1);
    drive(1'b1, 3, 9, 1'b0, 12, 1'b0);
    drive(1'b1, 3, 9, 1'b1, 10, 1'b0);
    drive(1'b1, 12, 5, 1'b0, 1, 1'b1);
    drive(1'b1, 12, 5, 1'b1, 7, 1'b1);
    idle(3);
    chk("dir_pass_count", 64'(pass_count), 6);
    chk("dir_fail_count", 64'(fail_count), 0);
    chk("dir_state", 64'(state), 1);
    chk("dir_err_sticky", 64'(err_sticky), 0);

    // Injected faults.
    drive(1'b1, 12, 5, 1'b1, 7, 1'b0);
    drive(1'b1, 5, 3, 1'b0, 9, 1'b0);
    idle(3);
    chk("fault_fail_count", 64'(fail_count), 2);
    chk("fault_ff_info", 64'(ff_info), 64'(14'b1_1100_0101_0_0111));
    chk("fault_state", 64'(state), 2);
    chk("fault_err_sticky", 64'(err_sticky), 1);

    // Saturation of the 3-bit counter.
    do_clear(1'b0);
    idle(1);
    chk("clr_state", 64'(state), 0);
    for (int i = 0; i < 10; i++) drive_good($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
    idle(3);
    chk("sat_pass_count3", 64'(pass_count3), 7);
    chk("sat_pass_count", 64'(pass_count), 10);

    // Clear with a tuple in flight, then clear coinciding with in_valid.
    drive_good(7, 2, 1'b1);
    do_clear(1'b0);
    idle(3);
    chk("clr_flight_pass_count", 64'(pass_count), 0);
    chk("clr_flight_state", 64'(state), 0);
    do_clear(1'b1);
    idle(3);
    chk("clr_same_pass_count", 64'(pass_count), 0);
    chk("clr_same_state", 64'(state), 0);

    // Sparse input spacing.
    for (int i = 0; i < 6; i++) begin
      drive_good($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
      idle(2);
    end
    idle(1);
    chk("sparse_pass_count", 64'(pass_count), 6);

    // Async reset with two tuples in flight.
    drive_good(1, 2, 1'b0);
    drive_good(9, 4, 1'b1);
    do_reset();
    idle(4);
    chk("post_rst_pass_count", 64'(pass_count), 0);

    // Randomized traffic with occasional faults and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_clear(1'($urandom));
      else if ($urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 99) < 80)
          drive_good($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
        else
          drive(1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                $urandom_range(0, 15), 1'($urandom));
      end else idle(1);
    end
    idle(4);
    chk("drain_queue_empty", 64'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
